feat_buf_window: RTL
====================

# feat_buf_window

Parametrised feature buffer with a built-in window scan engine. The host side writes a feature map of shape (H, W, C) with H and W powers of two and configurable at run time. On `start`, the buffer autonomously streams one of three window patterns with zero padding and valid/ready back-pressure: 3x3 convolution taps, 2x2 pooling taps, or a linear scan. It sits between the layer engines and the MAC/pool datapath and replaces the fixed per-layer conv/pool address wrappers.

## Interface
- `DATA_W`, 22: sample width, signed.
- `DEPTH`, 16384: word capacity, power of two; `AW = log2(DEPTH)`.
- `DIM_W`, 6: width of the y/x/c coordinate fields; each value is at most 63.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  write strobe.
- `wr_y`, `wr_x`, `wr_c`  in  DIM_W each  write coordinates.
- `wr_data`  in  DATA_W  write sample.
- `cfg_lgh`, `cfg_lgw`  in  3 each  log2 of H and W; sampled on `start`.
- `cfg_c`  in  DIM_W+1  channel count, 1..64; sampled on `start`.
- `cfg_mode`  in  2  0 = CONV3, 1 = POOL2, 2 = LINEAR, 3 = reserved.
- `start`  in  1  one-cycle pulse that begins a scan.
- `busy`  out  1  high while the scan engine is not IDLE.
- `done`  out  1  one-cycle pulse after the last output handshake.
- `cfg_err`  out  1  one-cycle pulse when `start` is rejected.
- `out_valid`  out  1  output handshake: valid.
- `out_ready`  in  1  output handshake: ready.
- `out_data`  out  DATA_W  tap sample; 0 for padding taps.
- `out_tap`  out  4  tap index.
- `out_y`, `out_x`, `out_c`  out  DIM_W each  output-pixel coordinates.
- `out_last`  out  1  marks the last tap of the whole scan.

## Operation
- Address map: addr = (c << (lgh+lgw)) | (y << lgw) | x. Writes use `y[lgh-1:0]` and `x[lgw-1:0]`.
- `wr_en` is honoured only in IDLE. Writes during `busy` are dropped.
- `start` is honoured only in IDLE. It is rejected with `cfg_err` if any of the following holds:
  - `cfg_mode` is 3;
  - `cfg_c` is 0;
  - `cfg_c << (lgh+lgw)` exceeds DEPTH;
  - mode is POOL2 and lgh or lgw is 0.
- FSM states:
  - IDLE: on a valid `start`, go to RUN.
  - RUN: go to DRAIN after the final tap is issued.
  - DRAIN: go to IDLE when the output queue is empty. `done` pulses in that cycle.
- Scan order, outer to inner: c, y, x, tap.
  - CONV3: y in 0..H-1, x in 0..W-1. Taps 0..8 at offsets (dy,dx) = (tap/3-1, tap%3-1).
  - POOL2: y in 0..H/2-1, x in 0..W/2-1. Taps 0..3 read (2y + tap[1], 2x + tap[0]). Output y and x are the pooled coordinates.
  - LINEAR: same y and x range as CONV3, tap 0 only.
- Padding: a tap whose source y is outside 0..H-1 or whose x is outside 0..W-1 performs no memory read. It still occupies an issue slot and emits `out_data` = 0.
- Output path: a 2-entry output queue fed by the read pipeline.
  - A tap is issued only if (queue occupancy + reads in flight) < 2.
  - Back-pressure never loses or duplicates a tap.
  - Output fields hold while `out_valid` is high and `out_ready` is low.
- `out_last` is set on exactly one beat: c = cfg_c-1, the last y, the last x, and the last tap.
- Asynchronous reset, including mid-scan:
  - FSM goes to IDLE and the queue is emptied.
  - Counters are cleared.
  - Memory contents are undefined.

## Timing
- Reset values: `busy`, `done`, `cfg_err`, `out_valid`, `out_last` = 0; `out_data`, `out_tap`, `out_y`, `out_x`, `out_c` = 0.
- Memory read latency is 1 cycle.
- `start` accepted in cycle 0:
  - `busy` is high from cycle 1;
  - the first `out_valid` is high in cycle 2.
- With `out_ready` held high, throughput is 1 tap per cycle with no bubbles.
- `done` pulses 1 cycle after the `out_last` handshake. `busy` falls in the same cycle as `done`.
- A write is visible to a scan started on the following cycle.
- `cfg_err` is asserted in the cycle after the rejected `start`; `busy` stays 0.

## Structure
- Package `feat_buf_pkg`:
  - mode encodings;
  - FSM state enum;
  - the CONV3 tap offset constants;
  - the address-composition function.
- Sub-module `feat_buf_ram`: simple dual-port RAM with 1-cycle registered read, `DATA_W` x `DEPTH`, inferred. The scan engine and output queue stay in the top module.

## Test plan
- CONV3 on a 4x4x1 map with value = 4y+x, `out_ready` tied high:
  - exactly 144 beats;
  - pixel (0,0) taps = 0,0,0,0,0,1,0,4,5;
  - `out_last` on the beat for pixel (3,3), tap 8;
  - `done` 1 cycle later.
- POOL2 on a 4x4x2 map with value = 16c+4y+x:
  - 32 beats;
  - pooled (c=1, y=1, x=0) taps = 24,25,28,29.
- LINEAR on 2x2x3 with `out_ready` toggling 1,0,0,1,...:
  - 12 beats in address order 0..11;
  - no repeated or missing beat;
  - outputs stable while stalled.
- Start with `cfg_c` = 64, lgh = lgw = 5, DEPTH = 16384 (65536 words required):
  - `cfg_err` pulses;
  - `busy` stays 0;
  - a following valid start runs normally.
- Writes during `busy` are dropped:
  - write 0x3FFFFF to (0,0,0) mid-scan;
  - the next LINEAR scan still returns the original value.
- Assert `rst_n` low for 1 cycle mid-CONV3 scan:
  - all outputs go to 0 immediately;
  - a new `start` after reset produces the full beat count.

Source files
------------

// File: rtl/feat_buf_pkg.sv
// feat_buf_pkg
//   Shared definitions for the feature buffer / window scan engine:
//   window mode encodings, scan FSM states, CONV3 tap offsets and the
//   (c, y, x) -> word address composition used by both write and scan paths.
package feat_buf_pkg;

   typedef enum logic [1:0] {
      MODE_CONV3  = 2'd0,
      MODE_POOL2  = 2'd1,
      MODE_LINEAR = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam logic [3:0] CONV3_LAST_TAP  = 4'd8;
   localparam logic [3:0] POOL2_LAST_TAP  = 4'd3;
   localparam logic [3:0] LINEAR_LAST_TAP = 4'd0;

   // CONV3 tap t reads (y + t/3 - 1, x + t%3 - 1)
   localparam logic signed [1:0] CONV3_DY [0:8] = '{2'sb11, 2'sb11, 2'sb11,
                                                   2'sb00, 2'sb00, 2'sb00,
                                                   2'sb01, 2'sb01, 2'sb01};
   localparam logic signed [1:0] CONV3_DX [0:8] = '{2'sb11, 2'sb00, 2'sb01,
                                                   2'sb11, 2'sb00, 2'sb01,
                                                   2'sb11, 2'sb00, 2'sb01};

   function automatic logic signed [1:0] conv3_dy(input logic [3:0] tap);
      logic signed [1:0] d;
      if (tap <= CONV3_LAST_TAP) d = CONV3_DY[tap];
      else                       d = 2'sb00;
      return d;
   endfunction

   function automatic logic signed [1:0] conv3_dx(input logic [3:0] tap);
      logic signed [1:0] d;
      if (tap <= CONV3_LAST_TAP) d = CONV3_DX[tap];
      else                       d = 2'sb00;
      return d;
   endfunction

   // addr = (c << (lgh+lgw)) | (y[lgh-1:0] << lgw) | x[lgw-1:0]
   function automatic logic [31:0] fb_addr(input logic [31:0] c,
                                           input logic [31:0] y,
                                           input logic [31:0] x,
                                           input logic [2:0]  lgh,
                                           input logic [2:0]  lgw);
      logic [31:0] ym;
      logic [31:0] xm;
      logic [3:0]  sh;
      ym = y & ((32'd1 << lgh) - 32'd1);
      xm = x & ((32'd1 << lgw) - 32'd1);
      sh = {1'b0, lgh} + {1'b0, lgw};   // 4 bits so 7+7 does not wrap
      return (c << sh) | (ym << lgw) | xm;
   endfunction

endpackage

// File: rtl/feat_buf_ram.sv
// feat_buf_ram
//   Simple dual-port RAM, DATA_W x DEPTH, one write port and one read port
//   with a 1-cycle registered read. Read-during-write returns the old word.
//   Ports: clk; we/waddr/wdata write port; re/raddr read request;
//          rdata read word, valid the cycle after re, held otherwise.
module feat_buf_ram #(
   parameter int DATA_W = 22,
   parameter int DEPTH  = 16384,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [0:DEPTH-1];

   // write port
   always_ff @(posedge clk) begin
      if (we) mem_r[waddr] <= wdata;
   end

   // registered read port
   always_ff @(posedge clk) begin
      if (re) rdata <= mem_r[raddr];
   end

endmodule

// File: rtl/feat_buf_window.sv
// feat_buf_window
//   Feature buffer (H x W x C, H/W powers of two) with a window scan engine
//   streaming CONV3 / POOL2 / LINEAR taps with zero padding.
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     wr_en/wr_y/wr_x/wr_c/wr_data  host write (IDLE only)
//     cfg_lgh/cfg_lgw/cfg_c/cfg_mode  scan config, sampled on start
//     start                      begin scan; busy/done/cfg_err status
//     out_valid/out_ready        output handshake
//     out_data/out_tap/out_y/out_x/out_c/out_last  output beat fields
module feat_buf_window
   import feat_buf_pkg::*;
#(
   parameter int DATA_W = 22,
   parameter int DEPTH  = 16384,
   parameter int DIM_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DIM_W-1:0]  wr_y,
   input  logic [DIM_W-1:0]  wr_x,
   input  logic [DIM_W-1:0]  wr_c,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [2:0]        cfg_lgh,
   input  logic [2:0]        cfg_lgw,
   input  logic [DIM_W:0]    cfg_c,
   input  logic [1:0]        cfg_mode,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [3:0]        out_tap,
   output logic [DIM_W-1:0]  out_y,
   output logic [DIM_W-1:0]  out_x,
   output logic [DIM_W-1:0]  out_c,
   output logic              out_last
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = DIM_W + 1;   // y/x counters reach 2^7-1 when lg=7

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [3:0]        tap;
      logic [DIM_W-1:0]  y;
      logic [DIM_W-1:0]  x;
      logic [DIM_W-1:0]  c;
      logic              last;
   } beat_t;
   localparam int BEAT_W = $bits(beat_t);

   state_e            state_r;
   mode_e             mode_r;
   logic [2:0]        lgh_r, lgw_r;
   logic [DIM_W:0]    cnum_r;
   logic [CW-1:0]     c_r, y_r, x_r;
   logic [3:0]        tap_r;
   logic              busy_r, done_r, cfg_err_r;

   logic              rd_vld_r, pad_r, last_r;
   logic [3:0]        mtap_r;
   logic [DIM_W-1:0]  my_r, mx_r, mc_r;
   logic [DATA_W-1:0] ram_q_s;

   beat_t             q0_r, q1_r, push_s;
   logic              v0_r, v1_r;

   mode_e             mode_s;
   logic [2:0]        lgh_s, lgw_s;
   logic [DIM_W:0]    cnum_s;
   logic [31:0]       ymax_s, xmax_s, cmax_s, need_s;
   logic [3:0]        tmax_s;
   logic              at_t_s, at_x_s, at_y_s, at_c_s, last_tap_s;
   int                sy_s, sx_s, h_s, w_s;
   logic              pad_s, cfg_ok_s, issue_s, pop_s, room_s, drain_done_s;
   logic [2:0]        occ_s;
   logic              ram_we_s, ram_re_s;

   // active scan config: live inputs while IDLE (first tap issues on start), latched otherwise
   always_comb begin
      if (state_r == ST_IDLE) begin
         mode_s = mode_e'(cfg_mode);
         lgh_s  = cfg_lgh;
         lgw_s  = cfg_lgw;
         cnum_s = cfg_c;
      end else begin
         mode_s = mode_r;
         lgh_s  = lgh_r;
         lgw_s  = lgw_r;
         cnum_s = cnum_r;
      end
   end

   // start validation against the live config inputs
   always_comb begin
      need_s   = 32'(cfg_c) << ({1'b0, cfg_lgh} + {1'b0, cfg_lgw});
      cfg_ok_s = (cfg_mode != 2'd3) && (cfg_c != {(DIM_W+1){1'b0}})
                 && (need_s <= 32'(DEPTH))
                 && !((cfg_mode == 2'd1) && ((cfg_lgh == 3'd0) || (cfg_lgw == 3'd0)));
   end

   // scan limits, wrap flags and source coordinate / padding of the current tap
   always_comb begin
      ymax_s = (32'd1 << lgh_s) - 32'd1;
      xmax_s = (32'd1 << lgw_s) - 32'd1;
      tmax_s = LINEAR_LAST_TAP;
      h_s    = int'(32'd1 << lgh_s);
      w_s    = int'(32'd1 << lgw_s);
      sy_s   = int'(y_r);
      sx_s   = int'(x_r);
      case (mode_s)
         MODE_CONV3: begin
            tmax_s = CONV3_LAST_TAP;
            sy_s   = int'(y_r) + int'(conv3_dy(tap_r));
            sx_s   = int'(x_r) + int'(conv3_dx(tap_r));
         end
         MODE_POOL2: begin
            tmax_s = POOL2_LAST_TAP;
            ymax_s = ((32'd1 << lgh_s) >> 1) - 32'd1;
            xmax_s = ((32'd1 << lgw_s) >> 1) - 32'd1;
            sy_s   = int'({y_r, 1'b0}) + int'(tap_r[1]);
            sx_s   = int'({x_r, 1'b0}) + int'(tap_r[0]);
         end
         MODE_LINEAR: begin
            tmax_s = LINEAR_LAST_TAP;
         end
         default: begin
            tmax_s = LINEAR_LAST_TAP;
         end
      endcase
      cmax_s     = 32'(cnum_s) - 32'd1;
      at_t_s     = (tap_r == tmax_s);
      at_x_s     = (32'(x_r) == xmax_s);
      at_y_s     = (32'(y_r) == ymax_s);
      at_c_s     = (32'(c_r) == cmax_s);
      last_tap_s = at_t_s && at_x_s && at_y_s && at_c_s;
      pad_s      = (sy_s < 0) || (sy_s >= h_s) || (sx_s < 0) || (sx_s >= w_s);
   end

   // issue gating; a slot freed by this cycle's pop counts as free, giving 1 tap/cycle
   always_comb begin
      pop_s  = v0_r && out_ready;
      occ_s  = {2'b00, v0_r} + {2'b00, v1_r} - {2'b00, pop_s} + {2'b00, rd_vld_r};
      room_s = (occ_s < 3'd2);
      case (state_r)
         ST_IDLE:  issue_s = start && cfg_ok_s;
         ST_RUN:   issue_s = room_s;
         default:  issue_s = 1'b0;
      endcase
      drain_done_s = !rd_vld_r && (!v0_r || (pop_s && !v1_r));
      ram_we_s     = wr_en && (state_r == ST_IDLE);
      ram_re_s     = issue_s && !pad_s;
   end

   feat_buf_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we_s),
      .waddr (AW'(fb_addr(32'(wr_c), 32'(wr_y), 32'(wr_x), cfg_lgh, cfg_lgw))),
      .wdata (wr_data),
      .re    (ram_re_s),
      .raddr (AW'(fb_addr(32'(c_r), 32'(sy_s), 32'(sx_s), lgh_s, lgw_s))),
      .rdata (ram_q_s)
   );

   // scan FSM, tap counters, read-pipeline metadata and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         mode_r    <= MODE_CONV3;
         lgh_r     <= 3'd0;
         lgw_r     <= 3'd0;
         cnum_r    <= {(DIM_W+1){1'b0}};
         c_r       <= {CW{1'b0}};
         y_r       <= {CW{1'b0}};
         x_r       <= {CW{1'b0}};
         tap_r     <= 4'd0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         cfg_err_r <= 1'b0;
         rd_vld_r  <= 1'b0;
         pad_r     <= 1'b0;
         last_r    <= 1'b0;
         mtap_r    <= 4'd0;
         my_r      <= {DIM_W{1'b0}};
         mx_r      <= {DIM_W{1'b0}};
         mc_r      <= {DIM_W{1'b0}};
      end else begin
         done_r    <= 1'b0;
         cfg_err_r <= 1'b0;
         rd_vld_r  <= issue_s;
         if (issue_s) begin
            pad_r  <= pad_s;
            last_r <= last_tap_s;
            mtap_r <= tap_r;
            my_r   <= y_r[DIM_W-1:0];
            mx_r   <= x_r[DIM_W-1:0];
            mc_r   <= c_r[DIM_W-1:0];
            // counters wrap to zero after the final tap, leaving IDLE ready for the next start
            if (at_t_s) begin
               tap_r <= 4'd0;
               if (at_x_s) begin
                  x_r <= {CW{1'b0}};
                  if (at_y_s) begin
                     y_r <= {CW{1'b0}};
                     if (at_c_s) c_r <= {CW{1'b0}};
                     else        c_r <= c_r + CW'(1'b1);
                  end else begin
                     y_r <= y_r + CW'(1'b1);
                  end
               end else begin
                  x_r <= x_r + CW'(1'b1);
               end
            end else begin
               tap_r <= tap_r + 4'd1;
            end
         end
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  if (cfg_ok_s) begin
                     mode_r  <= mode_e'(cfg_mode);
                     lgh_r   <= cfg_lgh;
                     lgw_r   <= cfg_lgw;
                     cnum_r  <= cfg_c;
                     busy_r  <= 1'b1;
                     state_r <= last_tap_s ? ST_DRAIN : ST_RUN;
                  end else begin
                     cfg_err_r <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (issue_s && last_tap_s) state_r <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (drain_done_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // beat landing from the read pipeline; padding taps carry zero
   always_comb begin
      push_s.data = pad_r ? {DATA_W{1'b0}} : ram_q_s;
      push_s.tap  = mtap_r;
      push_s.y    = my_r;
      push_s.x    = mx_r;
      push_s.c    = mc_r;
      push_s.last = last_r;
   end

   // 2-entry output queue; q0 is the presented head
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q0_r <= beat_t'({BEAT_W{1'b0}});
         q1_r <= beat_t'({BEAT_W{1'b0}});
         v0_r <= 1'b0;
         v1_r <= 1'b0;
      end else if (pop_s) begin
         if (v1_r) begin
            q0_r <= q1_r;
            if (rd_vld_r) q1_r <= push_s;
            else          v1_r <= 1'b0;
         end else begin
            if (rd_vld_r) q0_r <= push_s;
            else          v0_r <= 1'b0;
         end
      end else if (rd_vld_r) begin
         if (!v0_r) begin
            q0_r <= push_s;
            v0_r <= 1'b1;
         end else begin
            q1_r <= push_s;
            v1_r <= 1'b1;
         end
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign cfg_err   = cfg_err_r;
   assign out_valid = v0_r;
   assign out_data  = q0_r.data;
   assign out_tap   = q0_r.tap;
   assign out_y     = q0_r.y;
   assign out_x     = q0_r.x;
   assign out_c     = q0_r.c;
   assign out_last  = q0_r.last;

endmodule
